// File: rtl/counter_wrap_monitor.sv
// Watches an upstream counter for wrap events, measures the cycles between
// consecutive wraps and reports each measurement over a valid/ready handshake.
module counter_wrap_monitor #(
  parameter int CNT_W  = 4,
  parameter int PER_W  = 16,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              overflow_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PER_W-1:0]  out_period,
  output logic [WRAP_W-1:0] out_wraps,
  output logic              missed_out,
  output logic              busy
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_FIRST = 2'd1;
  localparam logic [1:0] S_MEASURE    = 2'd2;
  localparam logic [1:0] S_REPORT     = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_prev_cnt;
  logic              r_prev_vld;
  logic              r_prev_ovf;
  logic [PER_W-1:0]  r_period_cnt;
  logic              r_valid;
  logic [PER_W-1:0]  r_period;
  logic [WRAP_W-1:0] r_wraps;
  logic              r_missed;
  logic              r_busy;

  logic       w_wrap_det;
  logic       w_ovf_rise;
  logic       w_evt;
  logic [1:0] w_next_state;
  logic       w_arm_clear;
  logic       w_load;
  logic       w_count;
  logic       w_drop_valid;
  logic       w_set_missed;

  // A wrap seen on the counter value and an overflow edge in the same cycle
  // are the same physical event, so they merge into a single evt.
  assign w_wrap_det = r_prev_vld && (r_prev_cnt == '1) && (counter_in == '0);
  assign w_ovf_rise = overflow_in && !r_prev_ovf;
  assign w_evt      = w_wrap_det || w_ovf_rise;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_arm_clear  = 1'b0;
    w_load       = 1'b0;
    w_count      = 1'b0;
    w_drop_valid = 1'b0;
    w_set_missed = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_next_state = S_WAIT_FIRST;
          w_arm_clear  = 1'b1;
        end
      end
      S_WAIT_FIRST: begin
        if (w_evt)     w_next_state = S_MEASURE;
        else if (!arm) w_next_state = S_IDLE;
      end
      S_MEASURE: begin
        if (w_evt) begin
          w_next_state = S_REPORT;
          w_load       = 1'b1;
          w_count      = 1'b1;
        end else if (!arm) begin
          w_next_state = S_IDLE;
        end
      end
      S_REPORT: begin
        w_count = w_evt;
        if (out_ready) begin
          if (w_evt) begin
            w_load = 1'b1;
          end else begin
            w_drop_valid = 1'b1;
            w_next_state = arm ? S_MEASURE : S_IDLE;
          end
        end else begin
          // Consumer stalled: the held report survives, the new one is lost.
          w_set_missed = w_evt;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      r_state      <= S_IDLE;
      r_prev_cnt   <= '0;
      r_prev_vld   <= 1'b0;
      r_prev_ovf   <= 1'b0;
      r_period_cnt <= '0;
      r_valid      <= 1'b0;
      r_period     <= '0;
      r_wraps      <= '0;
      r_missed     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_prev_cnt <= counter_in;
      r_prev_ovf <= overflow_in;
      r_prev_vld <= 1'b1;

      if (w_evt)                    r_period_cnt <= PER_W'(1);
      else if (r_period_cnt != '1)  r_period_cnt <= r_period_cnt + PER_W'(1);

      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);

      if (w_arm_clear) begin
        r_wraps  <= '0;
        r_missed <= 1'b0;
      end else begin
        if (w_count && (r_wraps != '1)) r_wraps <= r_wraps + WRAP_W'(1);
        if (w_set_missed)               r_missed <= 1'b1;
      end

      if (w_load) begin
        r_period <= r_period_cnt;
        r_valid  <= 1'b1;
      end else if (w_drop_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_period = r_period;
  assign out_wraps  = r_wraps;
  assign missed_out = r_missed;
  assign busy       = r_busy;

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Randomized bench for counter_wrap_monitor: an event-time reference model feeds
// a report scoreboard; a second instance with a 4-bit period shows saturation.
module tb_counter_wrap_monitor;

  localparam int CNT_W     = 4;
  localparam int PER_W     = 16;
  localparam int WRAP_W    = 8;
  localparam int SAT_PER_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             arm;
  logic [CNT_W-1:0] counter_in;
  logic             overflow_in;
  logic             out_ready;

  logic                 out_valid, missed_out, busy;
  logic [PER_W-1:0]     out_period;
  logic [WRAP_W-1:0]    out_wraps;
  logic                 s_valid, s_missed, s_busy;
  logic [SAT_PER_W-1:0] s_period;
  logic [WRAP_W-1:0]    s_wraps;

  counter_wrap_monitor #(.CNT_W(CNT_W), .PER_W(PER_W), .WRAP_W(WRAP_W)) u_dut (
    .clk(clk), .reset(reset), .arm(arm), .counter_in(counter_in),
    .overflow_in(overflow_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_period(out_period), .out_wraps(out_wraps), .missed_out(missed_out),
    .busy(busy)
  );

  counter_wrap_monitor #(.CNT_W(CNT_W), .PER_W(SAT_PER_W), .WRAP_W(WRAP_W)) u_dut_sat (
    .clk(clk), .reset(reset), .arm(arm), .counter_in(counter_in),
    .overflow_in(overflow_in), .out_valid(s_valid), .out_ready(out_ready),
    .out_period(s_period), .out_wraps(s_wraps), .missed_out(s_missed),
    .busy(s_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint clip(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: tracks the cycle index of the last event; a period is
  // simply the difference of two event cycle indices, clipped to the width.
  typedef enum {M_IDLE, M_WAIT, M_MEAS, M_REP} mode_t;
  typedef struct {
    longint period_raw;
    int     wraps;
    bit     missed;
  } rep_t;

  rep_t   exp_q[$];
  mode_t  m_mode = M_IDLE;
  longint m_cycle = 0;
  longint m_last_evt = 0;
  bit     m_have_prev = 0;
  int     m_prev_cnt = 0;
  bit     m_prev_ovf = 0;
  longint m_rep_period = 0;
  int     m_wraps = 0;
  bit     m_missed = 0;
  bit     m_valid = 0;

  bit     started = 0;
  bit     e_valid, e_busy, e_missed;
  int     e_wraps;
  longint e_period_raw;

  task automatic model_step();
    bit     evt;
    longint period;
    e_valid      = m_valid;
    e_busy       = (m_mode != M_IDLE);
    e_missed     = m_missed;
    e_wraps      = m_wraps;
    e_period_raw = m_rep_period;
    started      = 1'b1;
    if (!reset) begin
      m_mode = M_IDLE; m_valid = 0; m_rep_period = 0; m_wraps = 0; m_missed = 0;
      m_have_prev = 0; m_prev_cnt = 0; m_prev_ovf = 0;
      m_last_evt = m_cycle + 1;
    end else begin
      evt = (m_have_prev && m_prev_cnt == (1 << CNT_W) - 1 && int'(counter_in) == 0)
            || (overflow_in && !m_prev_ovf);
      period = m_cycle - m_last_evt;
      case (m_mode)
        M_IDLE: if (arm) begin m_wraps = 0; m_missed = 0; m_mode = M_WAIT; end
        M_WAIT: if (evt) m_mode = M_MEAS; else if (!arm) m_mode = M_IDLE;
        M_MEAS: begin
          if (evt) begin
            m_rep_period = period;
            if (m_wraps < (1 << WRAP_W) - 1) m_wraps++;
            m_valid = 1;
            m_mode  = M_REP;
          end else if (!arm) m_mode = M_IDLE;
        end
        M_REP: begin
          if (out_ready) exp_q.push_back('{m_rep_period, m_wraps, m_missed});
          if (evt && m_wraps < (1 << WRAP_W) - 1) m_wraps++;
          if (out_ready) begin
            if (evt) m_rep_period = period;
            else begin m_valid = 0; m_mode = arm ? M_MEAS : M_IDLE; end
          end else if (evt) m_missed = 1;
        end
        default: m_mode = M_IDLE;
      endcase
      if (evt) m_last_evt = m_cycle;
      m_have_prev = 1;
      m_prev_cnt  = int'(counter_in);
      m_prev_ovf  = overflow_in;
    end
    m_cycle++;
  endtask

  // Monitor: per-cycle status comparison and scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (started) begin
      check("status", longint'({out_valid, busy, missed_out, out_wraps}),
            longint'({e_valid, e_busy, e_missed, WRAP_W'(e_wraps)}));
      check("sat_status", longint'({s_valid, s_busy, s_missed, s_wraps}),
            longint'({e_valid, e_busy, e_missed, WRAP_W'(e_wraps)}));
      check("period", longint'(out_period), clip(e_period_raw, PER_W));
      check("sat_period", longint'(s_period), clip(e_period_raw, SAT_PER_W));
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_report", 1, 0);
        end else begin
          rep_t r;
          r = exp_q.pop_front();
          check("rep_period", longint'(out_period), clip(r.period_raw, PER_W));
          check("rep_sat_period", longint'(s_period), clip(r.period_raw, SAT_PER_W));
          check("rep_wraps", longint'(out_wraps), longint'(r.wraps));
          check("rep_missed", longint'(missed_out), longint'(r.missed));
        end
      end
    end
  end

  // Upstream 4-bit enabled counter; its overflow pulse coincides with the 0.
  logic [CNT_W-1:0] up_cnt = '0;

  task automatic cycle(input bit en, input bit arm_v, input bit ready_v,
                       input bit rst_n_v, input bit glitch);
    bit ovf;
    @(posedge clk);
    #2;
    ovf = 1'b0;
    if (en) begin
      up_cnt = up_cnt + CNT_W'(1);
      ovf    = (up_cnt == '0);
    end
    counter_in  = up_cnt;
    overflow_in = ovf | glitch;
    arm         = arm_v;
    out_ready   = ready_v;
    reset       = rst_n_v;
    model_step();
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; counter_in = '0; overflow_in = 1'b0; out_ready = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Free-running counter, always ready
    repeat (60) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    // Half-rate enable
    for (int i = 0; i < 140; i++) cycle(i[0], 1'b1, 1'b1, 1'b1, 1'b0);
    // Backpressure across several wraps, then accept
    repeat (50) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (10) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    // Disarm, including while a report is held
    repeat (30) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // Reset while a report is pending, then re-arm
    repeat (40) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (45) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    // Long stall between wraps: saturates the narrow period counter
    repeat (20) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (40) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    // Randomized traffic with overflow glitches and sporadic resets
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 499) != 0,
            $urandom_range(0, 19) == 0);
    repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    check("queue_empty", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
